// File: rtl/pow_scan.sv
// Handshaked set-bit scanner: finds the highest (MSB mode) or lowest (LSB mode) set bit
// of a WIDTH-bit operand, SLICE bits per cycle, and flags zero / exact power-of-two operands.
module pow_scan #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic             in_lsb_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_pow,
  output logic             out_zero,
  output logic             out_pow2
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned PTR_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned OFF_W  = (SLICE > 1) ? $clog2(SLICE) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   num_q;
  logic               lsb_q;
  logic               pow2_q;
  logic [PTR_W-1:0]   ptr_q;

  logic [SLICE-1:0]   cur_slice;
  logic [IDX_W-1:0]   base;
  logic [OFF_W-1:0]   hi_off;
  logic [OFF_W-1:0]   lo_off;
  logic [IDX_W-1:0]   pow_val;
  logic               in_pow2;

  assign in_ready = (state_q == StIdle);

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign in_pow2 = (in_num != '0) && ((in_num & (in_num - WIDTH'(1))) == '0);

  always_comb begin
    cur_slice = '0;
    base      = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (ptr_q == PTR_W'(s)) begin
        cur_slice = num_q[s*SLICE +: SLICE];
        base      = IDX_W'(s * SLICE);
      end
    end
  end

  always_comb begin
    hi_off = '0;
    lo_off = '0;
    for (int i = 0; i < SLICE; i++) begin
      if (cur_slice[i]) hi_off = OFF_W'(i);
    end
    for (int i = SLICE - 1; i >= 0; i--) begin
      if (cur_slice[i]) lo_off = OFF_W'(i);
    end
  end

  assign pow_val = base + IDX_W'(lsb_q ? lo_off : hi_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      num_q     <= '0;
      lsb_q     <= 1'b0;
      pow2_q    <= 1'b0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_pow   <= '0;
      out_zero  <= 1'b0;
      out_pow2  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            num_q   <= in_num;
            lsb_q   <= in_lsb_mode;
            pow2_q  <= in_pow2;
            ptr_q   <= in_lsb_mode ? '0 : PTR_W'(NSLICE - 1);
            state_q <= StScan;
          end
        end
        StScan: begin
          if (num_q == '0) begin
            out_pow   <= '0;
            out_zero  <= 1'b1;
            out_pow2  <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else if (cur_slice != '0) begin
            out_pow   <= pow_val;
            out_zero  <= 1'b0;
            out_pow2  <= pow2_q;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            // A nonzero operand stops before the pointer can run off either end.
            ptr_q <= lsb_q ? ptr_q + PTR_W'(1) : ptr_q - PTR_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_scan.sv
// Bench for pow_scan: directed cases plus random operands checked against a bit-loop model.
module tb_pow_scan;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SLICE  = 8;
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic             in_lsb_mode;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_pow;
  logic             out_zero;
  logic             out_pow2;

  int n_vec = 0;
  int n_bad = 0;

  pow_scan #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_num      (in_num),
    .in_lsb_mode (in_lsb_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pow     (out_pow),
    .out_zero    (out_zero),
    .out_pow2    (out_pow2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: scan every bit, then derive slice count from the winning index.
  task automatic model(input logic [WIDTH-1:0] n, input bit lsb,
                       output int pow, output bit zero, output bit pow2, output int j);
    int ones = 0;
    int hi = -1;
    int lo = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (n[i]) begin
        ones++;
        hi = i;
        if (lo < 0) lo = i;
      end
    end
    zero = (ones == 0);
    pow2 = (ones == 1);
    if (zero) begin
      pow = 0;
      j   = 1;
    end else if (lsb) begin
      pow = lo;
      j   = lo / SLICE + 1;
    end else begin
      pow = hi;
      j   = NSLICE - hi / SLICE;
    end
  endtask

  // Called #1 after a clock edge. Leaves the bench #1 after the output handshake edge.
  task automatic run_op(input logic [WIDTH-1:0] n, input bit lsb, input int stall,
                        input bit keep_valid);
    int  e_pow, e_j, cnt;
    bit  e_zero, e_pow2;
    model(n, lsb, e_pow, e_zero, e_pow2, e_j);
    chk("in_ready_before", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_num      = n;
    in_lsb_mode = lsb;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
    in_num      = $urandom;
    in_lsb_mode = $urandom_range(0, 1);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!out_valid && cnt < 2 * NSLICE + 4);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("latency", 32'(cnt), 32'(e_j));
    chk("out_pow", 32'(out_pow), 32'(e_pow));
    chk("out_zero", 32'(out_zero), 32'(e_zero));
    chk("out_pow2", 32'(out_pow2), 32'(e_pow2));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pow", 32'(out_pow), 32'(e_pow));
      chk("stall_zero", 32'(out_zero), 32'(e_zero));
      chk("stall_pow2", 32'(out_pow2), 32'(e_pow2));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] rn;
    int               shape;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_num      = '0;
    in_lsb_mode = 1'b0;
    out_ready   = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pow", 32'(out_pow), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_pow2", 32'(out_pow2), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    run_op(32'h0000_0080, 1'b0, 0, 1'b0);
    run_op(32'h8000_0001, 1'b0, 0, 1'b0);
    run_op(32'h8000_0001, 1'b1, 0, 1'b0);
    run_op(32'h0000_0000, 1'b0, 0, 1'b0);
    run_op(32'h0000_0000, 1'b1, 0, 1'b0);
    run_op(32'h0001_0000, 1'b1, 0, 1'b0);
    run_op(32'h0001_0000, 1'b0, 0, 1'b0);
    run_op(32'h0000_0001, 1'b0, 0, 1'b0);
    run_op(32'h0000_0001, 1'b1, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 1'b1, 0, 1'b0);

    // Backpressure with in_valid held high; the next operand must follow right after
    run_op(32'h00F0_0000, 1'b0, 5, 1'b1);
    run_op(32'h0000_0100, 1'b1, 0, 1'b0);

    // Reset during SCAN of 0x1 (MSB mode)
    in_valid    = 1'b1;
    in_num      = 32'h0000_0001;
    in_lsb_mode = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_scan_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_scan_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("no_result_after_rst", 32'(out_valid), 32'd0);
    end
    run_op(32'h0000_0004, 1'b0, 0, 1'b0);

    // Reset while a result is waiting in DONE
    in_valid    = 1'b1;
    in_num      = 32'h4000_0000;
    in_lsb_mode = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("done_before_rst", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("done_rst_valid", 32'(out_valid), 32'd0);
    chk("done_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random operands of several shapes
    for (int k = 0; k < 40; k++) begin
      shape = $urandom_range(0, 4);
      case (shape)
        0:       rn = $urandom;
        1:       rn = 32'h1 << $urandom_range(0, WIDTH - 1);
        2:       rn = $urandom >> $urandom_range(0, WIDTH - 1);
        3:       rn = $urandom << $urandom_range(0, WIDTH - 1);
        default: rn = ($urandom_range(0, 3) == 0) ? '0 : 32'hFFFF_FFFF;
      endcase
      run_op(rn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop in case a handshake never completes
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pow_scan.md
Name: pow_scan

Overview:
- Parametrised, handshaked successor to the team's 8-bit floor-log2 encoder.
- Accepts a WIDTH-bit operand and scans it SLICE bits per cycle with an FSM.
- Reports the index of the highest set bit (MSB mode) or the lowest set bit (LSB mode), plus zero and exact-power-of-two flags.
- Sits between producer and consumer stages using valid/ready on both sides.

Parameters:
- WIDTH, 32, operand width; must be ≥2 and a multiple of SLICE.
- SLICE, 8, bits examined per scan cycle; NSLICE = WIDTH/SLICE.
- IDX_W, $clog2(WIDTH), index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand; equals (state==IDLE).
- in_num  in  WIDTH  operand.
- in_lsb_mode  in  1  0 = highest set bit, 1 = lowest set bit; sampled with in_num.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_pow  out  IDX_W  bit index of the selected set bit; 0 when the operand is zero.
- out_zero  out  1  operand was zero.
- out_pow2  out  1  operand had exactly one bit set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0, out_pow=0, out_zero=0, out_pow2=0.
  - in_ready=1 during and after reset.
  - Any in-flight operand is discarded and produces no result.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Accept when in_valid && in_ready.
  - On accept, register in_num, in_lsb_mode and pow2 = (popcount(in_num)==1).
  - Set slice pointer to NSLICE-1 (MSB mode) or 0 (LSB mode), then go to SCAN.
  - in_num may change freely after the accept edge.
- SCAN (one slice per cycle):
  - If the captured operand == 0: out_zero=1, out_pow=0, out_pow2=0, go to DONE on the first SCAN cycle.
  - Else, if the current slice is nonzero: out_pow = ptr*SLICE + (highest set-bit offset in slice in MSB mode, lowest in LSB mode); out_zero=0; go to DONE.
  - Else advance the pointer: decrement in MSB mode, increment in LSB mode.
  - A nonzero operand always terminates within NSLICE cycles; the pointer never wraps.
- DONE:
  - out_valid=1.
  - out_pow, out_zero and out_pow2 hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE and drop out_valid on that edge.
  - in_ready is 0 in DONE and SCAN; in_valid is ignored there.
  - No same-cycle output-handshake/input-accept overlap.
- Latency:
  - out_valid rises j clock edges after the accept edge, where j = number of slices examined (1..NSLICE).
  - A zero operand gives j=1.
  - Throughput: one result per j+2 cycles at best.
- Outputs are registered and are not updated outside SCAN→DONE transitions; their values are don't-care in IDLE/SCAN except out_valid=0.
- Compatibility: WIDTH=8, SLICE=8, MSB mode gives the same out_pow as the 8-bit floor-log2 encoder (0 for 0), with latency 1.
- Boundary cases:
  - Single bit at index WIDTH-1 or index 0: correct in both modes.
  - All-ones operand: out_pow2=0; out_pow = WIDTH-1 (MSB mode) or 0 (LSB mode).
- Reset asserted mid-SCAN or in DONE: out_valid falls immediately, asynchronously.

Test Plan:
- Default params, in_num=0x00000080, MSB mode → out_pow=7, out_pow2=1, out_zero=0, out_valid 4 edges after accept (slices 3,2,1,0).
- in_num=0x80000001, MSB mode → out_pow=31, out_pow2=0, j=1; same operand in LSB mode → out_pow=0, j=1.
- in_num=0x00000000 → out_zero=1, out_pow=0, out_pow2=0, j=1.
- in_num=0x00010000, LSB mode → out_pow=16, out_pow2=1, j=3; MSB mode → out_pow=16, j=2.
- Backpressure: result for 0x00F00000 (MSB mode, out_pow=23) with out_ready=0 for 5 cycles and in_valid=1 throughout → outputs stable and in_ready=0; after handshake, in_ready=1 the next cycle and the next operand is accepted.
- Reset mid-operation: rst_n pulled low during the SCAN of 0x00000001 (MSB mode) → out_valid=0 immediately, in_ready=1, no result after release; a following 0x00000004 (MSB mode) → out_pow=2, j=4.
